// File: rtl/rom_arbiter_if.sv
// rtl/rom_arbiter_if.sv - requester-side bus of the shared Rom arbiter
interface rom_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 18
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_data;

  modport master (
    output req, req_addr,
    input  gnt, rsp_valid, rsp_data
  );

  modport slave (
    input  req, req_addr,
    output gnt, rsp_valid, rsp_data
  );
endinterface

// File: rtl/rom_arbiter.sv
// rtl/rom_arbiter.sv - round-robin sharing of one 2-cycle-latency Rom among NUM_REQ requesters
module rom_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 18
) (
  input  logic              clka,
  input  logic              rst_n,
  rom_arbiter_if.slave      bus,
  output logic [ADDR_W-1:0] rom_addra,
  output logic              rom_ena,
  output logic              rom_oe,
  input  logic [DATA_W-1:0] rom_douta
);
  localparam int ID_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;

  logic [ID_W-1:0]    r_last;
  logic [ID_W-1:0]    w_gnt_idx;
  logic [NUM_REQ-1:0] w_gnt;
  logic               w_any;
  logic [NUM_REQ-1:0] r_s1;
  logic [NUM_REQ-1:0] r_s2;

  // round-robin scan starting just after the last granted port, wrapping
  always_comb begin : p_arb
    int v_idx;
    w_gnt     = '0;
    w_gnt_idx = r_last;
    w_any     = 1'b0;
    v_idx     = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      v_idx = (int'(r_last) + k) % NUM_REQ;
      if (!w_any && bus.req[v_idx]) begin
        w_any        = 1'b1;
        w_gnt[v_idx] = 1'b1;
        w_gnt_idx    = ID_W'(v_idx);
      end
    end
  end

  // Rom address follows the winner, parked at zero when nothing is issued
  always_comb begin
    rom_addra = '0;
    if (w_any) begin
      rom_addra = bus.req_addr[int'(w_gnt_idx)*ADDR_W +: ADDR_W];
    end
  end

  // pointer moves to the granted port; holds when idle
  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= ID_W'(NUM_REQ - 1);
    end else if (w_any) begin
      r_last <= w_gnt_idx;
    end
  end

  // grant tags travel alongside the Rom's two read stages; reset drops in-flight reads
  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= w_gnt;
      r_s2 <= r_s1;
    end
  end

  assign bus.gnt       = w_gnt;
  assign bus.rsp_valid = r_s2;
  assign bus.rsp_data  = rom_douta;
  assign rom_ena       = w_any;
  assign rom_oe        = |r_s2;
endmodule
